// File: rtl/scratch_pad_port_arbiter_pkg.sv
// Shared width helpers and request classification for the scratch pad port arbiter.
package scratch_pad_port_arbiter_pkg;

    function automatic int unsigned id_bits(input int unsigned n);
        return (n < 2) ? 32'd1 : 32'($clog2(n));
    endfunction

    function automatic int unsigned count_bits(input int unsigned depth);
        return 32'($clog2(depth)) + 32'd1;
    endfunction

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_READ,
        REQ_WRITE
    } req_kind_e;

endpackage

// File: rtl/arb_id_fifo.sv
// Register-based FIFO of client ids for outstanding reads; its count is the read credit counter.
module arb_id_fifo
    import scratch_pad_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ID_BITS  = 2,
    parameter int unsigned CNT_BITS = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [ID_BITS-1:0]  push_id,
    input  logic                pop,
    output logic [ID_BITS-1:0]  head_id,
    output logic                empty,
    output logic [CNT_BITS-1:0] count
);

    localparam int unsigned PTR_BITS = id_bits(DEPTH);

    logic [ID_BITS-1:0]  mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;

    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + PTR_BITS'(1);
    endfunction

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_id;
        end
    end

    assign head_id = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/scratch_pad_port_arbiter.sv
// Round-robin sharing of one scratch pad port; read responses are steered back in issue order.
module scratch_pad_port_arbiter
    import scratch_pad_port_arbiter_pkg::*;
#(
    parameter int unsigned CLIENTS         = 4,
    parameter int unsigned WIDTH           = 64,
    parameter int unsigned ADDR_WIDTH      = 12,
    parameter int unsigned MAX_OUTSTANDING = 32,
    parameter int unsigned CLIENT_BITS     = id_bits(CLIENTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CLIENTS-1:0]              c_rd_en,
    input  logic [CLIENTS-1:0]              c_wr_en,
    input  logic [CLIENTS*ADDR_WIDTH-1:0]   c_addr,
    input  logic [CLIENTS*WIDTH-1:0]        c_d,
    output logic [CLIENTS-1:0]              c_grant,
    output logic [WIDTH-1:0]                c_q,
    output logic [CLIENTS-1:0]              c_valid,
    input  logic [CLIENTS-1:0]              c_stall,
    output logic                            sp_rd_en,
    output logic                            sp_wr_en,
    output logic [ADDR_WIDTH-1:0]           sp_addr,
    output logic [WIDTH-1:0]                sp_d,
    input  logic                            sp_full,
    input  logic [WIDTH-1:0]                sp_q,
    input  logic                            sp_valid,
    output logic                            sp_stall,
    output logic [count_bits(MAX_OUTSTANDING)-1:0] outstanding,
    output logic                            protocol_err
);

    localparam int unsigned CNT_BITS = count_bits(MAX_OUTSTANDING);

    logic [ADDR_WIDTH-1:0]  addr_arr [CLIENTS];
    logic [WIDTH-1:0]       data_arr [CLIENTS];
    logic [CLIENTS-1:0]     elig;
    logic                   credit_ok;
    logic                   win_vld;
    logic [CLIENT_BITS-1:0] win_idx;
    logic [CLIENT_BITS-1:0] cand_idx;
    req_kind_e              win_kind;

    logic [CLIENT_BITS-1:0] rr_q, rr_d;
    logic                   sp_rd_en_q, sp_rd_en_d;
    logic                   sp_wr_en_q, sp_wr_en_d;
    logic [ADDR_WIDTH-1:0]  sp_addr_q, sp_addr_d;
    logic [WIDTH-1:0]       sp_d_q, sp_d_d;
    logic                   err_q, err_d;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_empty;
    logic [CLIENT_BITS-1:0] head_id;
    logic [CNT_BITS-1:0]    count;

    always_comb begin
        for (int unsigned i = 0; i < CLIENTS; i++) begin
            addr_arr[i] = c_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            data_arr[i] = c_d[i*WIDTH +: WIDTH];
        end
    end

    // A read consumed this cycle does not free its credit until the next cycle.
    always_comb begin
        credit_ok = (count < CNT_BITS'(MAX_OUTSTANDING));
        for (int unsigned i = 0; i < CLIENTS; i++) begin
            elig[i] = rst && !sp_full && (c_wr_en[i] || (c_rd_en[i] && credit_ok));
        end
    end

    // CLIENTS is a power of two, so the wrap is plain truncation of the index.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = rr_q;
        cand_idx = '0;
        for (int unsigned off = 0; off < CLIENTS; off++) begin
            cand_idx = rr_q + CLIENT_BITS'(off);
            if (!win_vld && elig[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    always_comb begin
        c_grant  = '0;
        win_kind = REQ_NONE;
        if (win_vld) begin
            c_grant[win_idx] = 1'b1;
            win_kind         = c_wr_en[win_idx] ? REQ_WRITE : REQ_READ;
        end
        rr_d       = win_vld ? win_idx + CLIENT_BITS'(1) : rr_q;
        sp_rd_en_d = (win_kind == REQ_READ);
        sp_wr_en_d = (win_kind == REQ_WRITE);
        sp_addr_d  = win_vld ? addr_arr[win_idx] : sp_addr_q;
        sp_d_d     = win_vld ? data_arr[win_idx] : sp_d_q;
    end

    always_comb begin
        c_valid  = '0;
        sp_stall = 1'b0;
        if (!fifo_empty) begin
            c_valid[head_id] = sp_valid;
            sp_stall         = c_stall[head_id];
        end
        fifo_push = (win_kind == REQ_READ);
        fifo_pop  = sp_valid && !sp_stall && !fifo_empty;
        err_d     = err_q || (|(c_rd_en & c_wr_en)) || (sp_valid && fifo_empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q       <= '0;
            sp_rd_en_q <= 1'b0;
            sp_wr_en_q <= 1'b0;
            sp_addr_q  <= '0;
            sp_d_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            sp_rd_en_q <= sp_rd_en_d;
            sp_wr_en_q <= sp_wr_en_d;
            sp_addr_q  <= sp_addr_d;
            sp_d_q     <= sp_d_d;
            err_q      <= err_d;
        end
    end

    arb_id_fifo #(
        .DEPTH    (MAX_OUTSTANDING),
        .ID_BITS  (CLIENT_BITS),
        .CNT_BITS (CNT_BITS)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push    (fifo_push),
        .push_id (win_idx),
        .pop     (fifo_pop),
        .head_id (head_id),
        .empty   (fifo_empty),
        .count   (count)
    );

    assign c_q          = sp_q;
    assign sp_rd_en     = sp_rd_en_q;
    assign sp_wr_en     = sp_wr_en_q;
    assign sp_addr      = sp_addr_q;
    assign sp_d         = sp_d_q;
    assign outstanding  = count;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_scratch_pad_port_arbiter.sv
// Directed bench for scratch_pad_port_arbiter with hand-computed expectations.
module tb_scratch_pad_port_arbiter;

    localparam int unsigned CLIENTS = 4;
    localparam int unsigned WIDTH   = 64;
    localparam int unsigned AW      = 12;
    localparam int unsigned MO      = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [CLIENTS-1:0]    c_rd_en, c_wr_en, c_grant, c_valid, c_stall;
    logic [CLIENTS*AW-1:0] c_addr;
    logic [CLIENTS*WIDTH-1:0] c_d;
    logic [WIDTH-1:0]      c_q, sp_d, sp_q;
    logic [AW-1:0]         sp_addr;
    logic                  sp_rd_en, sp_wr_en, sp_full, sp_valid, sp_stall, protocol_err;
    logic [5:0]            outstanding;

    int n_checks = 0;
    int n_errors = 0;
    int n_grants;

    always #5 clk = ~clk;

    scratch_pad_port_arbiter #(
        .CLIENTS         (CLIENTS),
        .WIDTH           (WIDTH),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .c_rd_en      (c_rd_en),
        .c_wr_en      (c_wr_en),
        .c_addr       (c_addr),
        .c_d          (c_d),
        .c_grant      (c_grant),
        .c_q          (c_q),
        .c_valid      (c_valid),
        .c_stall      (c_stall),
        .sp_rd_en     (sp_rd_en),
        .sp_wr_en     (sp_wr_en),
        .sp_addr      (sp_addr),
        .sp_d         (sp_d),
        .sp_full      (sp_full),
        .sp_q         (sp_q),
        .sp_valid     (sp_valid),
        .sp_stall     (sp_stall),
        .outstanding  (outstanding),
        .protocol_err (protocol_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        c_rd_en  = '1;
        c_wr_en  = '0;
        c_stall  = '0;
        sp_full  = 1'b0;
        sp_valid = 1'b0;
        sp_q     = '0;
        for (int i = 0; i < 4; i++) begin
            c_addr[i*AW +: AW]       = 12'h100 + 12'(i);
            c_d[i*WIDTH +: WIDTH]    = 64'h1000 + 64'(i);
        end
        #12;
        check("rst_grant", 64'(c_grant), 64'h0);
        check("rst_rd_en", 64'(sp_rd_en), 64'h0);
        check("rst_wr_en", 64'(sp_wr_en), 64'h0);
        check("rst_addr", 64'(sp_addr), 64'h0);
        check("rst_d", sp_d, 64'h0);
        check("rst_outstanding", 64'(outstanding), 64'h0);
        check("rst_err", 64'(protocol_err), 64'h0);
        check("rst_valid", 64'(c_valid), 64'h0);
        check("rst_sp_stall", 64'(sp_stall), 64'h0);
        @(negedge clk);
        rst     = 1'b1;
        c_rd_en = '0;
        @(posedge clk); #1;

        // Round robin with all clients reading: grants 0,1,2,3,0
        c_rd_en = '1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rr_grant", 64'(c_grant), 64'(4'b0001 << (i % 4)));
            @(posedge clk); #1;
            check("rr_sp_rd_en", 64'(sp_rd_en), 64'h1);
            check("rr_sp_addr", 64'(sp_addr), 64'h100 + 64'(i % 4));
        end
        c_rd_en = '0;
        #1;
        check("rr_idle_grant", 64'(c_grant), 64'h0);
        @(posedge clk); #1;
        check("rr_idle_rd_en", 64'(sp_rd_en), 64'h0);
        check("rr_addr_hold", 64'(sp_addr), 64'h100);
        check("rr_outstanding", 64'(outstanding), 64'd5);
        for (int i = 0; i < 5; i++) begin
            sp_valid = 1'b1;
            sp_q     = 64'hA0 + 64'(i);
            #1;
            check("rr_c_valid", 64'(c_valid), 64'(4'b0001 << (i % 4)));
            check("rr_c_q", c_q, 64'hA0 + 64'(i));
            @(posedge clk); #1;
        end
        sp_valid = 1'b0;
        check("rr_drained", 64'(outstanding), 64'h0);

        // Client 2 write then read of 0x010 (pointer now at 1)
        c_addr[2*AW +: AW]    = 12'h010;
        c_d[2*WIDTH +: WIDTH] = 64'hDEAD;
        c_wr_en = 4'b0100;
        #1;
        check("wr_grant", 64'(c_grant), 64'h4);
        @(posedge clk); #1;
        check("wr_sp_wr_en", 64'(sp_wr_en), 64'h1);
        check("wr_sp_rd_en", 64'(sp_rd_en), 64'h0);
        check("wr_sp_addr", 64'(sp_addr), 64'h010);
        check("wr_sp_d", sp_d, 64'hDEAD);
        c_wr_en = '0;
        c_rd_en = 4'b0100;
        #1;
        check("rd_grant", 64'(c_grant), 64'h4);
        @(posedge clk); #1;
        check("rd_sp_rd_en", 64'(sp_rd_en), 64'h1);
        check("rd_sp_wr_en", 64'(sp_wr_en), 64'h0);
        check("rd_sp_addr", 64'(sp_addr), 64'h010);
        check("rd_outstanding", 64'(outstanding), 64'd1);
        c_rd_en  = '0;
        sp_valid = 1'b1;
        sp_q     = 64'hDEAD;
        #1;
        check("rd_c_valid", 64'(c_valid), 64'h4);
        check("rd_c_q", c_q, 64'hDEAD);
        @(posedge clk); #1;
        sp_valid = 1'b0;
        check("rd_drained", 64'(outstanding), 64'h0);

        // Credit limit: pointer at 3, 40 cycles of reads with no responses
        n_grants = 0;
        c_rd_en  = '1;
        for (int i = 0; i < 40; i++) begin
            #1;
            check("credit_onehot", 64'($countones(c_grant) <= 1), 64'h1);
            if (c_grant != '0) n_grants++;
            @(posedge clk); #1;
        end
        check("credit_grants", 64'(n_grants), 64'd32);
        check("credit_outstanding", 64'(outstanding), 64'd32);
        #1;
        check("credit_blocked", 64'(c_grant), 64'h0);
        c_rd_en = '0;
        c_wr_en = 4'b0010;
        #1;
        check("credit_wr_grant", 64'(c_grant), 64'h2);
        @(posedge clk); #1;
        check("credit_wr_issue", 64'(sp_wr_en), 64'h1);
        c_wr_en  = '0;
        c_rd_en  = '1;
        sp_valid = 1'b1;
        #1;
        check("consume_no_grant", 64'(c_grant), 64'h0);
        check("consume_head", 64'(c_valid), 64'h8);
        @(posedge clk); #1;
        sp_valid = 1'b0;
        check("consume_outstanding", 64'(outstanding), 64'd31);
        #1;
        check("refill_grant", 64'(c_grant), 64'h4);
        @(posedge clk); #1;
        check("refill_outstanding", 64'(outstanding), 64'd32);
        #1;
        check("refill_blocked", 64'(c_grant), 64'h0);
        c_rd_en  = '0;
        sp_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
        end
        sp_valid = 1'b0;
        check("credit_drained", 64'(outstanding), 64'h0);

        // sp_full blocks all grants and freezes the pointer (at 3)
        c_rd_en = '1;
        sp_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("full_grant", 64'(c_grant), 64'h0);
            @(posedge clk); #1;
        end
        sp_full = 1'b0;
        #1;
        check("full_resume", 64'(c_grant), 64'h8);
        @(posedge clk); #1;
        c_rd_en  = '0;
        sp_valid = 1'b1;
        #1;
        check("full_resp", 64'(c_valid), 64'h8);
        @(posedge clk); #1;
        sp_valid = 1'b0;
        check("full_drained", 64'(outstanding), 64'h0);

        // Client 1 response stalled for three cycles
        c_rd_en = 4'b0010;
        #1;
        check("stall_grant", 64'(c_grant), 64'h2);
        @(posedge clk); #1;
        c_rd_en  = '0;
        sp_valid = 1'b1;
        c_stall  = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_sp_stall", 64'(sp_stall), 64'h1);
            check("stall_c_valid", 64'(c_valid), 64'h2);
            @(posedge clk); #1;
            check("stall_outstanding", 64'(outstanding), 64'd1);
        end
        c_stall = '0;
        #1;
        check("stall_release", 64'(sp_stall), 64'h0);
        check("stall_last_valid", 64'(c_valid), 64'h2);
        @(posedge clk); #1;
        sp_valid = 1'b0;
        check("stall_popped", 64'(outstanding), 64'h0);

        // Protocol errors: response with empty FIFO, then rd+wr together
        check("err_clear", 64'(protocol_err), 64'h0);
        sp_valid = 1'b1;
        #1;
        check("orphan_valid", 64'(c_valid), 64'h0);
        @(posedge clk); #1;
        sp_valid = 1'b0;
        check("orphan_err", 64'(protocol_err), 64'h1);
        check("orphan_outstanding", 64'(outstanding), 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("err_sticky", 64'(protocol_err), 64'h1);
        #2;
        rst = 1'b0;
        #1;
        check("err_reset", 64'(protocol_err), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        c_rd_en = 4'b0001;
        c_wr_en = 4'b0001;
        #1;
        check("both_grant", 64'(c_grant), 64'h1);
        @(posedge clk); #1;
        c_rd_en = '0;
        c_wr_en = '0;
        check("both_is_write", 64'(sp_wr_en), 64'h1);
        check("both_not_read", 64'(sp_rd_en), 64'h0);
        check("both_err", 64'(protocol_err), 64'h1);
        check("both_outstanding", 64'(outstanding), 64'h0);

        // Async reset in the middle of a read burst
        c_rd_en = '1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("burst_rd_en", 64'(sp_rd_en), 64'h1);
        check("burst_outstanding", 64'(outstanding), 64'd2);
        #2;
        rst = 1'b0;
        #1;
        check("areset_rd_en", 64'(sp_rd_en), 64'h0);
        check("areset_addr", 64'(sp_addr), 64'h0);
        check("areset_d", sp_d, 64'h0);
        check("areset_outstanding", 64'(outstanding), 64'h0);
        check("areset_grant", 64'(c_grant), 64'h0);
        check("areset_err", 64'(protocol_err), 64'h0);
        c_rd_en = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
